i2c_lat_seq: RTL and testbench
==============================

Name: i2c_lat_seq

Overview:
- Command sequencer for the Lattice EFB hard I2C primary core.
- Accepts byte-level write/read transactions from user logic and converts them into the required Wishbone register accesses: prescale/enable init, TXDR/CMDR writes, SR polling and RXDR reads.
- Sits between user logic and the EFB Wishbone slave port (lat_if side).
- Reports NACK, arbitration loss and poll timeout.

Parameters:
- BASE_ADDR, 8'h40: EFB I2C register base. CR=+0, CMDR=+1, BR0=+2, BR1=+3, TXDR=+4, SR=+5, RXDR=+7.
- PRESCALE, 16'd100: value written to BR1:BR0 at init.
- LEN_W, 8: width of the byte-count field.
- POLL_MAX, 1024: maximum SR reads per wait before a timeout.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous reset, active-high
- cmd_vld  in  1  command valid
- cmd_rdy  out  1  sequencer idle and initialised
- cmd_rw  in  1  0=write, 1=read
- cmd_addr  in  7  slave address
- cmd_len  in  LEN_W  data byte count; 0 = address probe
- wr_data  in  8  write byte
- wr_vld  in  1  write byte valid
- wr_rdy  out  1  write byte accepted
- rd_data  out  8  read byte
- rd_vld  out  1  read byte valid
- rd_rdy  in  1  read byte taken
- done  out  1  one-cycle pulse at transaction end
- err  out  2  status valid with done: 0 ok, 1 NACK, 2 arbitration lost, 3 timeout
- busy  out  1  transaction in progress
- wb_cyc, wb_stb  out  1  Wishbone cycle/strobe
- wb_we  out  1  write enable
- wb_adr  out  8  register address
- wb_dat_o  out  8  write data
- wb_dat_i  in  8  read data
- wb_ack  in  1  slave acknowledge

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values:
  - all outputs 0, wb_adr 0, err 0
  - state INIT0, internal counters cleared.
- Bus access rule:
  - wb_cyc=wb_stb=1 and adr/dat/we held stable until the first cycle with wb_ack=1.
  - Drop to 0 the cycle after ack; minimum one idle cycle between accesses.
  - No timeout on a missing ack: the sequencer waits indefinitely.
- INIT0..INIT2: write BR0=PRESCALE[7:0], then BR1=PRESCALE[15:8], then CR=8'h80. Go to IDLE.
- IDLE:
  - cmd_rdy=1.
  - On cmd_vld&cmd_rdy, latch rw/addr/len, clear err, set busy, go to ADDR.
  - cmd_rdy drops the cycle after acceptance.
- ADDR: write TXDR={addr,rw}, then CMDR=8'h94 (STA|WR|CKSDIS). Go to POLL with a TRRDY target.
- POLL:
  - Read SR each access; SR bits are TIP7, BUSY6, RARC5, ARBL3, TRRDY2.
  - ARBL=1 → err=2, go to STOP.
  - After an address or write phase, RARC=1 → err=1, go to STOP.
  - Target flag set → next phase.
  - POLL_MAX reads without the target → err=3, go to STOP.
  - Counter resets on every POLL entry.
- After address:
  - len==0 → STOP.
  - rw=0 → WDATA.
  - rw=1 → RCMD.
- WDATA:
  - wr_rdy=1 until wr_vld (handshake in one cycle).
  - Write TXDR=wr_data, then CMDR=8'h14, then POLL TRRDY.
  - Decrement remaining; at 0 → STOP.
- RCMD: write CMDR=8'h24, or 8'h2C (RD|ACK→NACK) when remaining==1. Then POLL TRRDY.
- RDATA:
  - Read RXDR; present rd_data with rd_vld=1 and hold until rd_rdy.
  - No bus activity while held.
  - Decrement remaining; at 0 → STOP, else RCMD.
- STOP:
  - Write CMDR=8'h44 (STO|CKSDIS), then poll SR until BUSY=0.
  - This poll is subject to timeout; a timeout here sets err=3 only if err was 0.
  - Then done=1 for one cycle, busy=0, return to IDLE.
- An error mid-write leaves the remaining wr bytes unconsumed; user logic is responsible for flushing them.
- Reset mid-transaction: immediate return to reset values. INIT is re-run; no STOP is issued.

Test Plan:
- Reset release, wb slave model acks in 1 cycle → writes 0x42=0x64, 0x43=0x00, 0x40=0x80 in order; cmd_rdy=1 afterwards.
- Write addr 0x50, len 2, data 0xA5,0x3C, no NACK → TXDR 0xA0, CMDR 0x94, TXDR 0xA5, CMDR 0x14, TXDR 0x3C, CMDR 0x14, CMDR 0x44; done with err=0.
- Read addr 0x50, len 3, RXDR returns 0x11,0x22,0x33, rd_rdy low for 5 cycles on byte 2 → CMDR 0x24,0x24,0x2C; rd_data 0x11,0x22,0x33 in order; no bus access during stall; err=0.
- Probe addr 0x2A, len 0, SR RARC=1 → TXDR 0x54, CMDR 0x94, then STOP 0x44; done with err=1.
- SR TRRDY never set, POLL_MAX=4 → exactly 4 SR reads, then STOP; err=3.
- rst asserted during WDATA → all outputs 0 next edge; INIT sequence repeats on release.

Source files
------------

// File: rtl/i2c_lat_seq.sv
// i2c_lat_seq: byte-level command sequencer for the Lattice EFB hard I2C
// primary. It turns user write/read transactions into the Wishbone register
// accesses the EFB expects: prescale/enable at init, TXDR/CMDR writes,
// SR polling and RXDR reads.
//
// Ports:
//   clk, rst                  system clock, async active-high reset
//   cmd_vld/cmd_rdy           command handshake (cmd_rw, cmd_addr, cmd_len)
//   wr_data/wr_vld/wr_rdy     write byte stream
//   rd_data/rd_vld/rd_rdy     read byte stream
//   done, err, busy           transaction status (err valid with done)
//   wb_*                      Wishbone master towards the EFB slave port
//
// state      | meaning
// -----------+--------------------------------------------------
// INIT0      | write BR0 = PRESCALE[7:0]
// INIT1      | write BR1 = PRESCALE[15:8]
// INIT2      | write CR  = 0x80 (core enable)
// IDLE       | ready for a command
// ADDR_TX    | write TXDR = {addr, rw}
// ADDR_CMD   | write CMDR = 0x94 (start + write)
// POLL       | read SR until the phase target, error or timeout
// WWAIT      | wait for a user write byte
// WTX        | write TXDR = data byte
// WCMD       | write CMDR = 0x14 (write)
// RCMD       | write CMDR = 0x24, or 0x2C for the last byte
// RRD        | read RXDR
// RHOLD      | present read byte until rd_rdy
// STOP_CMD   | write CMDR = 0x44 (stop)
// STOP_POLL  | read SR until BUSY clears or timeout
// DONE       | one-cycle done pulse

module i2c_lat_seq #(
  parameter logic [7:0]  BASE_ADDR = 8'h40,
  parameter logic [15:0] PRESCALE  = 16'd100,
  parameter int          LEN_W     = 8,
  parameter int          POLL_MAX  = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_vld,
  output logic             cmd_rdy,
  input  logic             cmd_rw,
  input  logic [6:0]       cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic [7:0]       wr_data,
  input  logic             wr_vld,
  output logic             wr_rdy,
  output logic [7:0]       rd_data,
  output logic             rd_vld,
  input  logic             rd_rdy,
  output logic             done,
  output logic [1:0]       err,
  output logic             busy,
  output logic             wb_cyc,
  output logic             wb_stb,
  output logic             wb_we,
  output logic [7:0]       wb_adr,
  output logic [7:0]       wb_dat_o,
  input  logic [7:0]       wb_dat_i,
  input  logic             wb_ack
);

  localparam int PC_W = $clog2(POLL_MAX + 1);

  localparam logic [7:0] A_CR   = BASE_ADDR + 8'd0;
  localparam logic [7:0] A_CMDR = BASE_ADDR + 8'd1;
  localparam logic [7:0] A_BR0  = BASE_ADDR + 8'd2;
  localparam logic [7:0] A_BR1  = BASE_ADDR + 8'd3;
  localparam logic [7:0] A_TXDR = BASE_ADDR + 8'd4;
  localparam logic [7:0] A_SR   = BASE_ADDR + 8'd5;
  localparam logic [7:0] A_RXDR = BASE_ADDR + 8'd7;

  typedef enum logic [3:0] {
    S_INIT0, S_INIT1, S_INIT2, S_IDLE,
    S_ADDR_TX, S_ADDR_CMD, S_POLL, S_WWAIT,
    S_WTX, S_WCMD, S_RCMD, S_RRD,
    S_RHOLD, S_STOP_CMD, S_STOP_POLL, S_DONE
  } state_t;

  typedef enum logic [1:0] {PH_ADDR, PH_WR, PH_RD} phase_t;

  state_t           state, state_nxt;
  phase_t           phase, phase_nxt;
  logic             wb_act, wb_act_nxt;
  logic             rw_q, rw_nxt;
  logic [6:0]       addr_q, addr_nxt;
  logic [LEN_W-1:0] rem_q, rem_nxt;
  logic [1:0]       err_q, err_nxt;
  logic [PC_W-1:0]  poll_cnt, poll_cnt_nxt;
  logic [7:0]       wbyte_q, wbyte_nxt;
  logic [7:0]       rdata_q, rdata_nxt;

  logic             acc_req, acc_we, acc_done, poll_last;
  logic [7:0]       acc_adr, acc_dat;

  assign acc_done  = wb_act & wb_ack;
  assign poll_last = (poll_cnt == PC_W'(POLL_MAX - 1));

  // Bus fields come from the current state, so they stay stable for the
  // whole access; gating with wb_act keeps them at zero while idle.
  assign wb_cyc   = wb_act;
  assign wb_stb   = wb_act;
  assign wb_we    = wb_act & acc_we;
  assign wb_adr   = wb_act ? acc_adr : 8'h00;
  assign wb_dat_o = (wb_act & acc_we) ? acc_dat : 8'h00;
  assign err      = err_q;
  assign rd_data  = rdata_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_INIT0;
      phase    <= PH_ADDR;
      wb_act   <= 1'b0;
      rw_q     <= 1'b0;
      addr_q   <= '0;
      rem_q    <= '0;
      err_q    <= '0;
      poll_cnt <= '0;
      wbyte_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state    <= state_nxt;
      phase    <= phase_nxt;
      wb_act   <= wb_act_nxt;
      rw_q     <= rw_nxt;
      addr_q   <= addr_nxt;
      rem_q    <= rem_nxt;
      err_q    <= err_nxt;
      poll_cnt <= poll_cnt_nxt;
      wbyte_q  <= wbyte_nxt;
      rdata_q  <= rdata_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    phase_nxt    = phase;
    wb_act_nxt   = 1'b0;
    rw_nxt       = rw_q;
    addr_nxt     = addr_q;
    rem_nxt      = rem_q;
    err_nxt      = err_q;
    poll_cnt_nxt = poll_cnt;
    wbyte_nxt    = wbyte_q;
    rdata_nxt    = rdata_q;
    acc_req      = 1'b0;
    acc_we       = 1'b0;
    acc_adr      = 8'h00;
    acc_dat      = 8'h00;
    cmd_rdy      = 1'b0;
    wr_rdy       = 1'b0;
    rd_vld       = 1'b0;
    done         = 1'b0;
    busy         = 1'b0;

    case (state)
      S_INIT0: begin
        acc_req = 1'b1; acc_we = 1'b1; acc_adr = A_BR0; acc_dat = PRESCALE[7:0];
        if (acc_done) state_nxt = S_INIT1;
      end
      S_INIT1: begin
        acc_req = 1'b1; acc_we = 1'b1; acc_adr = A_BR1; acc_dat = PRESCALE[15:8];
        if (acc_done) state_nxt = S_INIT2;
      end
      S_INIT2: begin
        acc_req = 1'b1; acc_we = 1'b1; acc_adr = A_CR; acc_dat = 8'h80;
        if (acc_done) state_nxt = S_IDLE;
      end
      S_IDLE: begin
        cmd_rdy = 1'b1;
        if (cmd_vld) begin
          rw_nxt    = cmd_rw;
          addr_nxt  = cmd_addr;
          rem_nxt   = cmd_len;
          err_nxt   = 2'd0;
          state_nxt = S_ADDR_TX;
        end
      end
      S_ADDR_TX: begin
        busy = 1'b1;
        acc_req = 1'b1; acc_we = 1'b1; acc_adr = A_TXDR; acc_dat = {addr_q, rw_q};
        if (acc_done) state_nxt = S_ADDR_CMD;
      end
      S_ADDR_CMD: begin
        busy = 1'b1;
        acc_req = 1'b1; acc_we = 1'b1; acc_adr = A_CMDR; acc_dat = 8'h94;
        if (acc_done) begin
          phase_nxt    = PH_ADDR;
          poll_cnt_nxt = '0;
          state_nxt    = S_POLL;
        end
      end
      S_POLL: begin
        busy = 1'b1;
        acc_req = 1'b1; acc_adr = A_SR;
        if (acc_done) begin
          // Priority: arbitration loss, then NACK (not meaningful while
          // reading), then the TRRDY target, then timeout.
          if (wb_dat_i[3]) begin
            err_nxt   = 2'd2;
            state_nxt = S_STOP_CMD;
          end else if (wb_dat_i[5] && (phase != PH_RD)) begin
            err_nxt   = 2'd1;
            state_nxt = S_STOP_CMD;
          end else if (wb_dat_i[2]) begin
            case (phase)
              PH_ADDR: begin
                if (rem_q == '0) state_nxt = S_STOP_CMD;
                else if (!rw_q)  state_nxt = S_WWAIT;
                else             state_nxt = S_RCMD;
              end
              PH_WR:   state_nxt = (rem_q == '0) ? S_STOP_CMD : S_WWAIT;
              default: state_nxt = S_RRD;
            endcase
          end else if (poll_last) begin
            err_nxt   = 2'd3;
            state_nxt = S_STOP_CMD;
          end else begin
            poll_cnt_nxt = poll_cnt + 1'b1;
          end
        end
      end
      S_WWAIT: begin
        busy   = 1'b1;
        wr_rdy = 1'b1;
        if (wr_vld) begin
          wbyte_nxt = wr_data;
          rem_nxt   = rem_q - 1'b1;
          state_nxt = S_WTX;
        end
      end
      S_WTX: begin
        busy = 1'b1;
        acc_req = 1'b1; acc_we = 1'b1; acc_adr = A_TXDR; acc_dat = wbyte_q;
        if (acc_done) state_nxt = S_WCMD;
      end
      S_WCMD: begin
        busy = 1'b1;
        acc_req = 1'b1; acc_we = 1'b1; acc_adr = A_CMDR; acc_dat = 8'h14;
        if (acc_done) begin
          phase_nxt    = PH_WR;
          poll_cnt_nxt = '0;
          state_nxt    = S_POLL;
        end
      end
      S_RCMD: begin
        busy = 1'b1;
        acc_req = 1'b1; acc_we = 1'b1; acc_adr = A_CMDR;
        // Last byte is read with NACK so the slave releases the bus.
        acc_dat = (rem_q == LEN_W'(1)) ? 8'h2C : 8'h24;
        if (acc_done) begin
          phase_nxt    = PH_RD;
          poll_cnt_nxt = '0;
          state_nxt    = S_POLL;
        end
      end
      S_RRD: begin
        busy = 1'b1;
        acc_req = 1'b1; acc_adr = A_RXDR;
        if (acc_done) begin
          rdata_nxt = wb_dat_i;
          state_nxt = S_RHOLD;
        end
      end
      S_RHOLD: begin
        busy   = 1'b1;
        rd_vld = 1'b1;
        if (rd_rdy) begin
          rem_nxt   = rem_q - 1'b1;
          state_nxt = (rem_q == LEN_W'(1)) ? S_STOP_CMD : S_RCMD;
        end
      end
      S_STOP_CMD: begin
        busy = 1'b1;
        acc_req = 1'b1; acc_we = 1'b1; acc_adr = A_CMDR; acc_dat = 8'h44;
        if (acc_done) begin
          poll_cnt_nxt = '0;
          state_nxt    = S_STOP_POLL;
        end
      end
      S_STOP_POLL: begin
        busy = 1'b1;
        acc_req = 1'b1; acc_adr = A_SR;
        if (acc_done) begin
          if (!wb_dat_i[6]) begin
            state_nxt = S_DONE;
          end else if (poll_last) begin
            // An earlier error is the more useful one to report.
            if (err_q == 2'd0) err_nxt = 2'd3;
            state_nxt = S_DONE;
          end else begin
            poll_cnt_nxt = poll_cnt + 1'b1;
          end
        end
      end
      S_DONE: begin
        done      = 1'b1;
        state_nxt = S_IDLE;
      end
      default: state_nxt = S_INIT0;
    endcase

    // Request goes up one cycle after entering an access state (guaranteed
    // idle gap) and drops the cycle after ack.
    wb_act_nxt = acc_req & ~acc_done;
  end

endmodule

// File: tb/tb_i2c_lat_seq.sv
// Directed bench for i2c_lat_seq with a one-cycle-ack Wishbone slave model.
module tb_i2c_lat_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       cmd_vld = 1'b0, cmd_rdy, cmd_rw = 1'b0;
  logic [6:0] cmd_addr = 7'h00;
  logic [7:0] cmd_len = 8'h00;
  logic [7:0] wr_data = 8'h00;
  logic       wr_vld = 1'b0, wr_rdy;
  logic [7:0] rd_data;
  logic       rd_vld, rd_rdy = 1'b0;
  logic       done, busy;
  logic [1:0] err;
  logic       wb_cyc, wb_stb, wb_we, wb_ack;
  logic [7:0] wb_adr, wb_dat_o, wb_dat_i;

  logic [7:0] sr_val = 8'h04;
  int         rx_cnt;
  logic [16:0] log_q[$];
  int         log_base = 0;
  int         stall_bus = 0;
  logic [15:0] exp_w[$];
  logic [7:0] exp_rd[3] = '{8'h11, 8'h22, 8'h33};

  int tests_run = 0;
  int tests_failed = 0;

  i2c_lat_seq #(.BASE_ADDR(8'h40), .PRESCALE(16'd100), .LEN_W(8), .POLL_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_vld(cmd_vld), .cmd_rdy(cmd_rdy), .cmd_rw(cmd_rw), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .wr_data(wr_data), .wr_vld(wr_vld), .wr_rdy(wr_rdy),
    .rd_data(rd_data), .rd_vld(rd_vld), .rd_rdy(rd_rdy),
    .done(done), .err(err), .busy(busy),
    .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack(wb_ack)
  );

  always #5 clk = ~clk;

  // Slave: ack one cycle after the strobe is seen, log every access.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_ack   <= 1'b0;
      wb_dat_i <= 8'h00;
      rx_cnt   <= 0;
    end else begin
      wb_ack <= 1'b0;
      if (wb_cyc && wb_stb && !wb_ack) begin
        wb_ack <= 1'b1;
        if (wb_we) begin
          log_q.push_back({1'b1, wb_adr, wb_dat_o});
        end else if (wb_adr == 8'h47) begin
          wb_dat_i <= exp_rd[rx_cnt % 3];
          log_q.push_back({1'b0, wb_adr, exp_rd[rx_cnt % 3]});
          rx_cnt <= rx_cnt + 1;
        end else begin
          wb_dat_i <= sr_val;
          log_q.push_back({1'b0, wb_adr, sr_val});
        end
      end
    end
  end

  always @(posedge clk) if (rd_vld && wb_cyc) stall_bus <= stall_bus + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return cmd_rdy;
      1: return done;
      2: return wr_rdy;
      default: return rd_vld;
    endcase
  endfunction

  task automatic wait_for(input int sel, input string tag);
    int n = 0;
    while (!sig(sel) && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_wait"}, {31'd0, sig(sel)}, 32'd1);
  endtask

  task automatic check_writes(input string tag);
    logic [15:0] got[$];
    for (int i = log_base; i < log_q.size(); i++)
      if (log_q[i][16]) got.push_back(log_q[i][15:0]);
    chk({tag, "_nwr"}, got.size(), exp_w.size());
    for (int i = 0; i < exp_w.size(); i++)
      chk($sformatf("%s_wr%0d", tag, i),
          (i < got.size()) ? {16'h0, got[i]} : 32'hDEAD_BEEF, {16'h0, exp_w[i]});
  endtask

  function automatic int count_reads(input logic [7:0] adr);
    int n = 0;
    for (int i = log_base; i < log_q.size(); i++)
      if (!log_q[i][16] && log_q[i][15:8] == adr) n++;
    return n;
  endfunction

  // SR reads between the start command and the stop command.
  function automatic int addr_polls();
    int  n = 0;
    logic on = 1'b0;
    for (int i = log_base; i < log_q.size(); i++) begin
      if (log_q[i] == {1'b1, 16'h4194}) on = 1'b1;
      else if (log_q[i] == {1'b1, 16'h4144}) on = 1'b0;
      else if (on && !log_q[i][16] && log_q[i][15:8] == 8'h45) n++;
    end
    return n;
  endfunction

  task automatic start_cmd(input logic rw, input logic [6:0] a, input logic [7:0] len, input string tag);
    wait_for(0, {tag, "_rdy"});
    log_base = log_q.size();
    cmd_vld = 1'b1; cmd_rw = rw; cmd_addr = a; cmd_len = len;
    @(negedge clk);
    cmd_vld = 1'b0;
    chk({tag, "_accept"}, {30'd0, cmd_rdy, busy}, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b, input string tag);
    wait_for(2, tag);
    wr_vld = 1'b1; wr_data = b;
    @(negedge clk);
    wr_vld = 1'b0;
  endtask

  task automatic wait_done(input string tag, input logic [1:0] exp_err);
    wait_for(1, {tag, "_done"});
    chk({tag, "_err"}, {30'd0, err}, {30'd0, exp_err});
    @(negedge clk);
    chk({tag, "_pulse"}, {30'd0, done, busy}, 32'd0);
  endtask

  function automatic logic [31:0] all_outs();
    return {wb_cyc, wb_stb, wb_we, wb_adr, wb_dat_o, cmd_rdy, wr_rdy, rd_vld,
            done, busy, err} | {24'd0, rd_data};
  endfunction

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outs", all_outs(), 32'd0);
    rst = 1'b0;
    log_base = 0;

    // Init sequence
    wait_for(0, "init");
    exp_w = '{16'h4264, 16'h4300, 16'h4080};
    check_writes("init");

    // Write 0x50, two bytes
    sr_val = 8'h04;
    start_cmd(1'b0, 7'h50, 8'd2, "wr");
    send_byte(8'hA5, "wr_b0");
    send_byte(8'h3C, "wr_b1");
    wait_done("wr", 2'd0);
    exp_w = '{16'h44A0, 16'h4194, 16'h44A5, 16'h4114, 16'h443C, 16'h4114, 16'h4144};
    check_writes("wr");

    // Read 0x50, three bytes with a stall on the second
    start_cmd(1'b1, 7'h50, 8'd3, "rd");
    for (int i = 0; i < 3; i++) begin
      wait_for(3, $sformatf("rd_vld%0d", i));
      chk($sformatf("rd_data%0d", i), {24'd0, rd_data}, {24'd0, exp_rd[i]});
      if (i == 1) begin
        repeat (5) begin
          @(negedge clk);
          chk("rd_stall_hold", {23'd0, rd_vld, rd_data}, {23'd0, 1'b1, 8'h22});
        end
      end
      rd_rdy = 1'b1;
      @(negedge clk);
      rd_rdy = 1'b0;
    end
    wait_done("rd", 2'd0);
    exp_w = '{16'h44A1, 16'h4194, 16'h4124, 16'h4124, 16'h412C, 16'h4144};
    check_writes("rd");
    chk("rd_rxdr_reads", count_reads(8'h47), 32'd3);
    chk("rd_stall_bus", stall_bus, 32'd0);

    // Probe 0x2A answered with NACK
    sr_val = 8'h20;
    start_cmd(1'b0, 7'h2A, 8'd0, "nack");
    wait_done("nack", 2'd1);
    exp_w = '{16'h4454, 16'h4194, 16'h4144};
    check_writes("nack");

    // TRRDY never set: timeout after exactly POLL_MAX reads
    sr_val = 8'h00;
    start_cmd(1'b0, 7'h10, 8'd0, "tmo");
    wait_done("tmo", 2'd3);
    exp_w = '{16'h4420, 16'h4194, 16'h4144};
    check_writes("tmo");
    chk("tmo_polls", addr_polls(), 32'd4);

    // Arbitration lost, bus stays busy: stop-poll timeout keeps err=2
    sr_val = 8'h48;
    start_cmd(1'b0, 7'h10, 8'd0, "arb");
    wait_done("arb", 2'd2);
    chk("arb_polls", addr_polls(), 32'd1);
    chk("arb_stop_polls", count_reads(8'h45), 32'd5);

    // Reset during WDATA
    sr_val = 8'h04;
    start_cmd(1'b0, 7'h50, 8'd2, "rst");
    wait_for(2, "rst_wwait");
    rst = 1'b1;
    #1;
    chk("rst_async_outs", all_outs(), 32'd0);
    @(negedge clk);
    chk("rst_edge_outs", all_outs(), 32'd0);
    log_base = log_q.size();
    rst = 1'b0;
    wait_for(0, "reinit");
    exp_w = '{16'h4264, 16'h4300, 16'h4080};
    check_writes("reinit");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
